vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, meaning horizontal front-porch clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync-pulse clocks.
REQ-004 The block SHALL have parameter H_BACK, default 48, meaning horizontal back-porch clocks.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, meaning vertical front-porch lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vertical sync-pulse lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, meaning vertical back-porch lines.
REQ-009 The block SHALL have parameter SYNC_POL, default 0, meaning the asserted level of hsync/vsync (0 = active-low).
REQ-010 The block SHALL have port clk_div, input, 1 bit: the pixel clock (25 MHz); it is the only clock.
REQ-011 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-012 The block SHALL have port pixel_x, output, 10 bits: current horizontal count, 0..H_TOTAL-1.
REQ-013 The block SHALL have port pixel_y, output, 10 bits: current vertical count, 0..V_TOTAL-1.
REQ-014 The block SHALL have port video_on, output, 1 bit: high when the pixel is in the visible region.
REQ-015 The block SHALL have port hsync, output, 1 bit: horizontal sync.
REQ-016 The block SHALL have port vsync, output, 1 bit: vertical sync.
REQ-017 The block SHALL have port line_tick, output, 1 bit: one-cycle pulse on the last clock of each line.
REQ-018 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse on the last clock of each frame.

Function
REQ-019 The block SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL likewise (525).
REQ-020 pixel_x SHALL increment by 1 every clk_div and wrap from H_TOTAL-1 to 0.
REQ-021 pixel_y SHALL increment by 1 only on the cycle where pixel_x wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-022 Each axis SHALL run a four-state FSM with states VISIBLE, FRONT, SYNC and BACK, sequenced VISIBLE->FRONT->SYNC->BACK->VISIBLE, with each transition taken when the axis count crosses the corresponding boundary.
REQ-023 The vertical FSM SHALL advance only on line-wrap cycles.
REQ-024 All outputs SHALL be registered and mutually aligned: in any cycle, hsync, vsync, video_on and the ticks SHALL describe the pixel_x/pixel_y presented in that same cycle, with zero relative skew.
REQ-025 video_on SHALL be 1 iff pixel_x < H_VISIBLE and pixel_y < V_VISIBLE (pixel_x 0..639, pixel_y 0..479).
REQ-026 hsync SHALL equal SYNC_POL iff 656 <= pixel_x < 752; otherwise it SHALL equal ~SYNC_POL.
REQ-027 vsync SHALL equal SYNC_POL iff 490 <= pixel_y < 492; otherwise it SHALL equal ~SYNC_POL.
REQ-028 line_tick SHALL be 1 iff pixel_x == H_TOTAL-1.
REQ-029 frame_tick SHALL be 1 iff pixel_x == H_TOTAL-1 and pixel_y == V_TOTAL-1.
REQ-030 Counter arithmetic SHALL be 10-bit unsigned, and the counters SHALL never take values >= H_TOTAL or >= V_TOTAL.

Reset
REQ-031 While reset is high, the block SHALL hold pixel_x=0, pixel_y=0, video_on=0, hsync=~SYNC_POL, vsync=~SYNC_POL, line_tick=0, frame_tick=0, with both FSMs in VISIBLE.
REQ-032 On the first clk_div edge after reset deasserts, pixel_x SHALL become 1 and video_on SHALL become 1.
REQ-033 Reset asserted mid-line or mid-frame SHALL return all state to the REQ-031 values immediately, without waiting for a clock edge.

Structure
REQ-034 The timing defaults, derived totals and the axis-state enumeration SHALL reside in the shared package vga_timing_pkg.
REQ-035 One sub-module, vga_axis_counter (count, FSM, sync and wrap outputs), SHALL be instantiated twice: once for the horizontal axis and once for the vertical axis, with the vertical instance enabled by the horizontal wrap.

Verification
REQ-036 Reset held 5 cycles, then released -> all outputs match REQ-031 during reset; pixel_x=1, video_on=1 after the first edge.
REQ-037 Run one full line -> hsync asserted low for exactly 96 cycles beginning at pixel_x=656; line_tick high only at pixel_x=799; pixel_y steps 0->1.
REQ-038 Run one full frame (420000 cycles) -> exactly one frame_tick, at (799,524); vsync low for lines 490-491 only (1600 cycles); pixel_y wraps to 0.
REQ-039 Count video_on high cycles over one frame -> exactly 307200.
REQ-040 Assert reset at (400,300), then release -> outputs return to REQ-031 values asynchronously, and counting restarts at (0,0).
REQ-041 Set SYNC_POL=1 -> hsync and vsync are inverted relative to the default build, with identical timing.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60), derived totals and the per-axis region state.
package vga_timing_pkg;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;
   localparam bit          SYNC_POL_DEF  = 1'b0;

   localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   typedef enum logic [1:0] {
      AX_VISIBLE = 2'd0,
      AX_FRONT   = 2'd1,
      AX_SYNC    = 2'd2,
      AX_BACK    = 2'd3
   } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus region FSM; sync is registered against the next count
// so it lines up with the count register, and next-cycle flags are exported for the top's registers.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned VISIBLE  = H_VISIBLE_DEF,
   parameter int unsigned FRONT    = H_FRONT_DEF,
   parameter int unsigned SYNC     = H_SYNC_DEF,
   parameter int unsigned BACK     = H_BACK_DEF,
   parameter bit          SYNC_POL = SYNC_POL_DEF
) (
   input  logic             clk_div,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             sync,
   output logic             vis_nxt_c,
   output logic             last_nxt_c
);

   localparam int unsigned      TOTAL       = VISIBLE + FRONT + SYNC + BACK;
   localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(VISIBLE);
   localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(VISIBLE + FRONT);
   localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(VISIBLE + FRONT + SYNC);
   localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);

   axis_state_t      state, state_nxt;
   logic [CNT_W-1:0] count_nxt;

   always_ff @(posedge clk_div or posedge reset) begin
      if (reset) begin
         state <= AX_VISIBLE;
         count <= '0;
         sync  <= ~SYNC_POL;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         sync  <= (state_nxt == AX_SYNC) ? SYNC_POL : ~SYNC_POL;
      end
   end

   // Region changes are keyed on the count value the axis is about to present.
   always_comb begin
      count_nxt = count;
      state_nxt = state;
      if (en) begin
         count_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
         unique case (state)
            AX_VISIBLE: if (count_nxt == FRONT_START) state_nxt = AX_FRONT;
            AX_FRONT:   if (count_nxt == SYNC_START)  state_nxt = AX_SYNC;
            AX_SYNC:    if (count_nxt == BACK_START)  state_nxt = AX_BACK;
            AX_BACK:    if (count_nxt == '0)          state_nxt = AX_VISIBLE;
            default:                                  state_nxt = AX_VISIBLE;
         endcase
      end
      vis_nxt_c  = (state_nxt == AX_VISIBLE);
      last_nxt_c = (count_nxt == LAST);
   end

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: horizontal axis free-runs, vertical axis steps on each line wrap;
// every output is a register describing the pixel_x/pixel_y presented in the same cycle.
module vga_sync
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF,
   parameter bit          SYNC_POL  = SYNC_POL_DEF
) (
   input  logic             clk_div,
   input  logic             reset,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             video_on,
   output logic             hsync,
   output logic             vsync,
   output logic             line_tick,
   output logic             frame_tick
);

   logic h_vis_nxt_c, h_last_nxt_c;
   logic v_vis_nxt_c, v_last_nxt_c;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .SYNC_POL(SYNC_POL)
   ) u_h_axis (
      .clk_div   (clk_div),
      .reset     (reset),
      .en        (1'b1),
      .count     (pixel_x),
      .sync      (hsync),
      .vis_nxt_c (h_vis_nxt_c),
      .last_nxt_c(h_last_nxt_c)
   );

   // line_tick marks pixel_x == H_TOTAL-1, i.e. the cycle whose edge wraps the line.
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .SYNC_POL(SYNC_POL)
   ) u_v_axis (
      .clk_div   (clk_div),
      .reset     (reset),
      .en        (line_tick),
      .count     (pixel_y),
      .sync      (vsync),
      .vis_nxt_c (v_vis_nxt_c),
      .last_nxt_c(v_last_nxt_c)
   );

   always_ff @(posedge clk_div or posedge reset) begin
      if (reset) begin
         video_on   <= 1'b0;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         video_on   <= h_vis_nxt_c & v_vis_nxt_c;
         line_tick  <= h_last_nxt_c;
         frame_tick <= h_last_nxt_c & v_last_nxt_c;
      end
   end

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: default-timing instance for reset and line checks, plus two reduced-timing
// instances (25x13 totals, active-low and active-high sync) for whole-frame checks.
module tb_vga_sync;

   logic clk_div = 1'b0;
   logic reset   = 1'b0;

   always #5 clk_div = ~clk_div;

   logic [9:0] d_x, d_y, s_x, s_y, i_x, i_y;
   logic d_von, d_hs, d_vs, d_lt, d_ft;
   logic s_von, s_hs, s_vs, s_lt, s_ft;
   logic i_von, i_hs, i_vs, i_lt, i_ft;

   vga_sync u_dut (
      .clk_div(clk_div), .reset(reset), .pixel_x(d_x), .pixel_y(d_y), .video_on(d_von),
      .hsync(d_hs), .vsync(d_vs), .line_tick(d_lt), .frame_tick(d_ft)
   );

   // Small timing: H 16/2/3/4 (total 25, sync x 18..20), V 6/2/2/3 (total 13, sync y 8..9).
   vga_sync #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
   ) u_small (
      .clk_div(clk_div), .reset(reset), .pixel_x(s_x), .pixel_y(s_y), .video_on(s_von),
      .hsync(s_hs), .vsync(s_vs), .line_tick(s_lt), .frame_tick(s_ft)
   );

   vga_sync #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
   ) u_small_inv (
      .clk_div(clk_div), .reset(reset), .pixel_x(i_x), .pixel_y(i_y), .video_on(i_von),
      .hsync(i_hs), .vsync(i_vs), .line_tick(i_lt), .frame_tick(i_ft)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_div);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, " d_x"},   32'(d_x),   0);
      check_eq({tag, " d_y"},   32'(d_y),   0);
      check_eq({tag, " d_von"}, 32'(d_von), 0);
      check_eq({tag, " d_hs"},  32'(d_hs),  1);
      check_eq({tag, " d_vs"},  32'(d_vs),  1);
      check_eq({tag, " d_lt"},  32'(d_lt),  0);
      check_eq({tag, " d_ft"},  32'(d_ft),  0);
      check_eq({tag, " s_x"},   32'(s_x),   0);
      check_eq({tag, " s_y"},   32'(s_y),   0);
      check_eq({tag, " i_hs"},  32'(i_hs),  0);
      check_eq({tag, " i_vs"},  32'(i_vs),  0);
   endtask

   // Default-instance line statistics
   int hs_low = 0, hs_first = -1, hs_last = -1, lt_cnt = 0, lt_x = -1, d_ft_cnt = 0;
   // Small-instance frame statistics
   int s_von_cnt = 0, s_ft_cnt = 0, s_ft_x = -1, s_ft_y = -1;
   int s_vs_cnt = 0, s_vs_ymin = 99, s_vs_ymax = -1, s_hs_cnt = 0;
   int inv_mis = 0, inv_hs_cnt = 0;

   initial begin
      #2 reset = 1'b1;
      repeat (5) step();
      check_reset_state("hold");

      reset = 1'b0;
      for (int i = 1; i <= 800; i++) begin
         step();
         if (i == 1) begin
            check_eq("first d_x",   32'(d_x),   1);
            check_eq("first d_von", 32'(d_von), 1);
            check_eq("first s_x",   32'(s_x),   1);
            check_eq("first s_von", 32'(s_von), 1);
         end
         if (i <= 799) begin
            if (d_hs == 1'b0) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(d_x);
               hs_last = int'(d_x);
            end
            if (d_lt) begin
               lt_cnt++;
               lt_x = int'(d_x);
            end
            if (d_ft) d_ft_cnt++;
            if (i == 639) check_eq("von x639", 32'(d_von), 1);
            if (i == 640) check_eq("von x640", 32'(d_von), 0);
            if (i == 655) check_eq("hs x655",  32'(d_hs),  1);
            if (i == 752) check_eq("hs x752",  32'(d_hs),  1);
            if (i == 700) check_eq("vs line0", 32'(d_vs),  1);
         end
         if (i <= 325) begin
            if (s_von) s_von_cnt++;
            if (s_ft) begin
               s_ft_cnt++;
               s_ft_x = int'(s_x);
               s_ft_y = int'(s_y);
            end
            if (s_vs == 1'b0) begin
               s_vs_cnt++;
               if (int'(s_y) < s_vs_ymin) s_vs_ymin = int'(s_y);
               if (int'(s_y) > s_vs_ymax) s_vs_ymax = int'(s_y);
            end
            if (s_hs == 1'b0) s_hs_cnt++;
            if (i_hs == 1'b1) inv_hs_cnt++;
            if (i_hs !== ~s_hs || i_vs !== ~s_vs) inv_mis++;
            if (i == 325) begin
               check_eq("s wrap x", 32'(s_x), 0);
               check_eq("s wrap y", 32'(s_y), 0);
            end
         end
      end

      check_eq("line hs_low",   32'(hs_low),   96);
      check_eq("line hs_first", 32'(hs_first), 656);
      check_eq("line hs_last",  32'(hs_last),  751);
      check_eq("line lt_cnt",   32'(lt_cnt),   1);
      check_eq("line lt_x",     32'(lt_x),     799);
      check_eq("line no ft",    32'(d_ft_cnt), 0);
      check_eq("line end x",    32'(d_x),      0);
      check_eq("line end y",    32'(d_y),      1);

      check_eq("frame von_cnt", 32'(s_von_cnt), 96);
      check_eq("frame ft_cnt",  32'(s_ft_cnt),  1);
      check_eq("frame ft_x",    32'(s_ft_x),    24);
      check_eq("frame ft_y",    32'(s_ft_y),    12);
      check_eq("frame vs_cnt",  32'(s_vs_cnt),  50);
      check_eq("frame vs_ymin", 32'(s_vs_ymin), 8);
      check_eq("frame vs_ymax", 32'(s_vs_ymax), 9);
      check_eq("frame hs_cnt",  32'(s_hs_cnt),  39);
      check_eq("inv hs_cnt",    32'(inv_hs_cnt), 39);
      check_eq("inv mismatch",  32'(inv_mis),   0);

      // Walk to small (12,7) / default (37,1), then reset between clock edges.
      repeat (37) step();
      check_eq("pre-rst s_x", 32'(s_x), 12);
      check_eq("pre-rst s_y", 32'(s_y), 7);
      check_eq("pre-rst d_x", 32'(d_x), 37);
      check_eq("pre-rst d_y", 32'(d_y), 1);
      #2 reset = 1'b1;
      #1;
      check_reset_state("async");
      step();
      check_reset_state("async hold");
      reset = 1'b0;
      step();
      check_eq("restart d_x", 32'(d_x), 1);
      check_eq("restart d_y", 32'(d_y), 0);
      check_eq("restart s_x", 32'(s_x), 1);
      check_eq("restart s_y", 32'(s_y), 0);
      check_eq("restart von", 32'(d_von), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
